mio_uart_tx: RTL and testbench

MIO_UART_TX -- requirements
Module: mio_uart_tx

---
 rtl/mio_uart_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 53 +++++
 rtl/mio_uart_tx.sv | 168 ++++++++++++++++
 tb/tb_mio_uart_tx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mio_uart_pkg.sv
// Shared register map, STATUS bit positions, TX FSM states and reset defaults for mio_uart_tx.
package mio_uart_pkg;

    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_DIV    = 4'h8;
    localparam logic [3:0] ADDR_RSVD   = 4'hC;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    localparam int DIV_RST_DEFAULT = 868;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    // A divisor of zero still gives a one-cycle bit.
    function automatic logic [15:0] bit_len(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, zero-latency head read; a push into a full FIFO lands only when a pop
// frees a slot in the same cycle, and pops of an empty FIFO are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mio_uart_tx.sv
// MIO bus UART transmitter: bus access acked with registered rdata one cycle later; DATA writes
// to a full FIFO are dropped and flagged in STATUS.ovf. Define MIO_UART_PARITY_EN for an even parity bit.
module mio_uart_tx
    import mio_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_RST    = DIV_RST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        mem_w,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        txd,
    output logic        tx_irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    uart_state_e   state;
    logic [15:0]   div;
    logic [15:0]   bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    tx_byte;
    logic          ovf;

    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic          fifo_push;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;

    logic          bit_done;
    logic          wr_data;
    logic          overflow;
    logic          status_rd;
    logic [31:0]   status_word;
    logic          unused_bits;

    assign unused_bits = ^wdata[31:16];

    assign bit_done  = (bit_cnt <= 16'd1);
    assign fifo_pop  = !fifo_empty && ((state == IDLE) || (state == STOP && bit_done));
    assign wr_data   = sel && mem_w && (addr == ADDR_DATA);
    assign fifo_push = wr_data && (!fifo_full || fifo_pop);
    assign overflow  = wr_data && fifo_full && !fifo_pop;
    assign status_rd = sel && !mem_w && (addr == ADDR_STATUS);
    assign tx_irq    = fifo_empty && (state == IDLE);

    always_comb begin
        status_word                     = '0;
        status_word[ST_BUSY]            = (state != IDLE);
        status_word[ST_FULL]            = fifo_full;
        status_word[ST_EMPTY]           = fifo_empty;
        status_word[ST_OVF]             = ovf;
        status_word[ST_CNT_LSB +: 4]    = 4'(fifo_count);
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat (wdata[7:0]),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ready <= 1'b0;
            rdata <= '0;
            ovf   <= 1'b0;
            div   <= 16'(DIV_RST);
        end else begin
            ready <= sel;
            rdata <= '0;
            if (sel && !mem_w) begin
                case (addr)
                    ADDR_STATUS: rdata <= status_word;
                    ADDR_DIV:    rdata <= {16'b0, div};
                    default:     rdata <= '0;
                endcase
            end
            if (sel && mem_w && addr == ADDR_DIV) begin
                div <= wdata[15:0];
            end
            // A same-cycle overflow wins over the read-to-clear.
            if (overflow) begin
                ovf <= 1'b1;
            end else if (status_rd) begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            txd     <= 1'b1;
            bit_cnt <= '0;
            bit_idx <= '0;
            tx_byte <= '0;
        end else if (state == IDLE) begin
            if (!fifo_empty) begin
                state   <= START;
                txd     <= 1'b0;
                tx_byte <= fifo_head;
                bit_cnt <= bit_len(div);
            end
        end else if (!bit_done) begin
            bit_cnt <= bit_cnt - 16'd1;
        end else begin
            // Divisor is sampled only here, so a DIV write never stretches the bit in flight.
            bit_cnt <= bit_len(div);
            case (state)
                START: begin
                    state   <= DATA;
                    txd     <= tx_byte[0];
                    bit_idx <= 3'd0;
                end
                DATA: begin
                    bit_idx <= bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef MIO_UART_PARITY_EN
                        state <= PARITY;
                        txd   <= ^tx_byte;
`else
                        state <= STOP;
                        txd   <= 1'b1;
`endif
                    end else begin
                        txd <= tx_byte[bit_idx + 3'd1];
                    end
                end
`ifdef MIO_UART_PARITY_EN
                PARITY: begin
                    state <= STOP;
                    txd   <= 1'b1;
                end
`endif
                STOP: begin
                    if (!fifo_empty) begin
                        state   <= START;
                        txd     <= 1'b0;
                        tx_byte <= fifo_head;
                    end else begin
                        state <= IDLE;
                        txd   <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mio_uart_tx.sv
// Directed plus randomized bench for mio_uart_tx against a bit-list frame model.
module tb_mio_uart_tx;
    import mio_uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        mem_w;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        txd;
    logic        tx_irq;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  q[$];
    logic [7:0]  b1;
    logic [7:0]  b2;
    int          d;
    int          n;

    always #5 clk = ~clk;

    mio_uart_tx dut (
        .clk    (clk),
        .rst    (rst),
        .sel    (sel),
        .mem_w  (mem_w),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .ready  (ready),
        .txd    (txd),
        .tx_irq (tx_irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int blen(input int dv);
        return (dv == 0) ? 1 : dv;
    endfunction

    // Called just after a falling edge; returns one cycle later, at the falling edge where ready is due.
    task automatic bus_op(input logic w, input logic [3:0] a, input logic [31:0] dat, output logic [31:0] rd);
        sel   = 1'b1;
        mem_w = w;
        addr  = a;
        wdata = dat;
        @(negedge clk);
        chk("ready", 32'(ready), 32'd1);
        rd    = rdata;
        sel   = 1'b0;
        mem_w = 1'b0;
        addr  = '0;
        wdata = '0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] dat);
        logic [31:0] unused_rd;
        bus_op(1'b1, a, dat, unused_rd);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] r;
        bus_op(1'b0, a, 32'd0, r);
        chk(tag, r, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Expected line: start 0, data LSB first, optional even parity, stop 1.
    task automatic check_frame(input logic [7:0] b, input int start_len, input int len);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef MIO_UART_PARITY_EN
        bits.push_back(^b);
`endif
        bits.push_back(1'b1);
        foreach (bits[k]) begin
            int l;
            l = (k == 0) ? start_len : len;
            repeat (l) begin
                chk($sformatf("txd byte=%02h bit=%0d", b, k), 32'(txd), 32'(bits[k]));
                chk("tx_irq busy", 32'(tx_irq), 32'd0);
                @(negedge clk);
            end
        end
    endtask

    task automatic run_frames(input logic [7:0] fq[$], input int start_len, input int len, input int new_div);
        fork
            begin
                foreach (fq[i]) wr(ADDR_DATA, 32'(fq[i]));
                if (new_div >= 0) begin
                    @(negedge clk);
                    wr(ADDR_DIV, 32'(new_div));
                end
            end
            begin
                repeat (2) @(negedge clk);
                foreach (fq[i]) check_frame(fq[i], (i == 0) ? start_len : len, len);
            end
        join
        chk("txd idle after frames", 32'(txd), 32'd1);
        chk("tx_irq after frames", 32'(tx_irq), 32'd1);
    endtask

    initial begin
        rst   = 1'b1;
        sel   = 1'b0;
        mem_w = 1'b0;
        addr  = '0;
        wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset txd", 32'(txd), 32'd1);
        chk("reset ready", 32'(ready), 32'd0);
        chk("reset rdata", rdata, 32'd0);
        chk("reset tx_irq", 32'(tx_irq), 32'd1);
        rst = 1'b0;

        rd_chk("status after reset", ADDR_STATUS, 32'h4);
        @(negedge clk);
        chk("ready single pulse", 32'(ready), 32'd0);
        rd_chk("div after reset", ADDR_DIV, 32'd868);
        wr(ADDR_RSVD, 32'hFFFF_FFFF);
        rd_chk("reserved read", ADDR_RSVD, 32'd0);
        rd_chk("data read", ADDR_DATA, 32'd0);
        rd_chk("div after rsvd write", ADDR_DIV, 32'd868);

        wr(ADDR_DIV, 32'hABCD_0004);
        rd_chk("div readback", ADDR_DIV, 32'd4);
        q = '{8'h55};
        run_frames(q, 4, 4, -1);

        wr(ADDR_DIV, 32'd2);
        q = '{8'h00, 8'hFF};
        run_frames(q, 2, 2, -1);

        wr(ADDR_DIV, 32'd0);
        q = '{8'($urandom)};
        run_frames(q, 1, 1, -1);

        wr(ADDR_DIV, 32'd3);
        q = '{8'($urandom)};
        run_frames(q, 3, 6, 6);

        for (int it = 0; it < 5; it++) begin
            d = $urandom_range(0, 4);
            n = $urandom_range(1, 4);
            q.delete();
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            wr(ADDR_DIV, 32'(d));
            run_frames(q, blen(d), blen(d), -1);
        end

        wr(ADDR_DIV, 32'd100);
        for (int i = 0; i < 6; i++) wr(ADDR_DATA, 32'(8'h10 + i));
        rd_chk("status overflow", ADDR_STATUS, 32'h4B);
        rd_chk("status ovf cleared", ADDR_STATUS, 32'h43);
        chk("tx_irq while queued", 32'(tx_irq), 32'd0);
        do_reset();

        wr(ADDR_DIV, 32'd4);
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        wr(ADDR_DATA, 32'(b1));
        wr(ADDR_DATA, 32'(b2));
        repeat (17) @(negedge clk);
        chk("txd in bit 3", 32'(txd), 32'(b1[3]));
        rst   = 1'b1;
        sel   = 1'b1;
        mem_w = 1'b1;
        addr  = ADDR_DATA;
        wdata = 32'hAA;
        @(negedge clk);
        chk("txd after mid-frame reset", 32'(txd), 32'd1);
        chk("no ready for reset-cycle access", 32'(ready), 32'd0);
        chk("rdata after reset", rdata, 32'd0);
        chk("tx_irq after reset", 32'(tx_irq), 32'd1);
        rst   = 1'b0;
        sel   = 1'b0;
        mem_w = 1'b0;
        wdata = '0;
        @(negedge clk);
        chk("ready stays low after reset", 32'(ready), 32'd0);
        chk("txd stays idle", 32'(txd), 32'd1);
        rd_chk("status after mid-frame reset", ADDR_STATUS, 32'h4);
        rd_chk("div after mid-frame reset", ADDR_DIV, 32'd868);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
